clock_time_set: RTL and testbench

- Upstream control stage for the 4-digit BCD time counter.
- Synchronizes and debounces two board push-buttons (mode, up) and runs a set-time FSM: RUN, then SET_HR, then SET_MIN.
- On exit from SET_MIN, emits a one-cycle load pulse with the edited BCD time for the counter to adopt.
- Also drives a digit blink mask for the display stage.

---
 rtl/clock_time_set.sv | 187 ++++++++++++++++++
 tb/tb_clock_time_set.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_set.sv
// Button conditioning and RUN/SET_HR/SET_MIN time-set FSM; optional auto-repeat under CLOCK_TIME_SET_AUTOREPEAT_EN.
// Raw edge to press pulse is DEBOUNCE_CYCLES+3 cycles; there is no backpressure, and load pulses one cycle on exit from SET_MIN.
module clock_time_set #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int HOUR_MODE       = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic [3:0] cur_min0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_hr0,
  input  logic [3:0] cur_hr1,
  output logic [3:0] set_min0,
  output logic [3:0] set_min1,
  output logic [3:0] set_hr0,
  output logic [3:0] set_hr1,
  output logic       load,
  output logic       setting,
  output logic [3:0] blink_mask
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [3:0] RST_HR1 = (HOUR_MODE == 12) ? 4'd1 : 4'd0;
  localparam logic [3:0] RST_HR0 = (HOUR_MODE == 12) ? 4'd2 : 4'd0;

  if (!(HOUR_MODE == 12 || HOUR_MODE == 24) || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("clock_time_set: illegal parameter value");
  end

  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;

  // bit 0 = mode button, bit 1 = up button
  logic [1:0]     raw, sync1, sync2, deb, deb_q, press;
  logic [DCW-1:0] db_cnt [2];
  logic           mode_p, up_p, inc, rep_fire;

  assign raw    = {btn_up, btn_mode};
  assign mode_p = press[0];
  assign up_p   = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t state;

`ifdef CLOCK_TIME_SET_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_CYCLES + 1);
  logic [RCW-1:0] rep_cnt;

  // mode_p always changes state, so it suppresses and clears the repeat
  assign rep_fire = (state != RUN) && deb[1] && !mode_p && (rep_cnt == RCW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (state == RUN || !deb[1] || mode_p || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign inc = up_p | rep_fire;

  logic       hr_ok, min_ok;
  logic [3:0] cap_hr1, cap_hr0, cap_min1, cap_min0;
  logic [3:0] nxt_hr1, nxt_hr0, nxt_min1, nxt_min0;

  always_comb begin
    if (HOUR_MODE == 12)
      hr_ok = (cur_hr1 == 4'd0 && cur_hr0 != 4'd0 && cur_hr0 <= 4'd9) ||
              (cur_hr1 == 4'd1 && cur_hr0 <= 4'd2);
    else
      hr_ok = (cur_hr1 <= 4'd1 && cur_hr0 <= 4'd9) ||
              (cur_hr1 == 4'd2 && cur_hr0 <= 4'd3);
    min_ok   = (cur_min1 <= 4'd5) && (cur_min0 <= 4'd9);
    cap_hr1  = hr_ok  ? cur_hr1  : RST_HR1;
    cap_hr0  = hr_ok  ? cur_hr0  : RST_HR0;
    cap_min1 = min_ok ? cur_min1 : 4'd0;
    cap_min0 = min_ok ? cur_min0 : 4'd0;
  end

  always_comb begin
    nxt_hr1 = set_hr1;
    nxt_hr0 = set_hr0 + 4'd1;
    if (HOUR_MODE == 12 && set_hr1 == 4'd1 && set_hr0 == 4'd2) begin
      nxt_hr1 = 4'd0;
      nxt_hr0 = 4'd1;
    end else if (HOUR_MODE == 24 && set_hr1 == 4'd2 && set_hr0 == 4'd3) begin
      nxt_hr1 = 4'd0;
      nxt_hr0 = 4'd0;
    end else if (set_hr0 == 4'd9) begin
      nxt_hr1 = set_hr1 + 4'd1;
      nxt_hr0 = 4'd0;
    end

    nxt_min1 = set_min1;
    nxt_min0 = set_min0 + 4'd1;
    if (set_min0 == 4'd9) begin
      nxt_min0 = 4'd0;
      nxt_min1 = (set_min1 == 4'd5) ? 4'd0 : set_min1 + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      set_hr1    <= RST_HR1;
      set_hr0    <= RST_HR0;
      set_min1   <= 4'd0;
      set_min0   <= 4'd0;
      load       <= 1'b0;
      setting    <= 1'b0;
      blink_mask <= 4'b0000;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (mode_p) begin
            state      <= SET_HR;
            set_hr1    <= cap_hr1;
            set_hr0    <= cap_hr0;
            set_min1   <= cap_min1;
            set_min0   <= cap_min0;
            setting    <= 1'b1;
            blink_mask <= 4'b1100;
          end
        end
        SET_HR: begin
          if (mode_p) begin
            state      <= SET_MIN;
            blink_mask <= 4'b0011;
          end else if (inc) begin
            set_hr1 <= nxt_hr1;
            set_hr0 <= nxt_hr0;
          end
        end
        SET_MIN: begin
          if (mode_p) begin
            state      <= RUN;
            load       <= 1'b1;
            setting    <= 1'b0;
            blink_mask <= 4'b0000;
          end else if (inc) begin
            set_min1 <= nxt_min1;
            set_min0 <= nxt_min0;
          end
        end
        default: begin
          state      <= RUN;
          setting    <= 1'b0;
          blink_mask <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_set.sv
// Self-checking bench for clock_time_set: directed vector table, bounce and reset corners, and random presses against a time model.
module tb_clock_time_set;

  localparam int DEB = 4;
  localparam int REP = 16;

  logic clk, rst_n;
  logic btn_mode, btn_up, btn_mode24, btn_up24;
  logic [15:0] cur, cur24;
  logic [3:0] s_hr1, s_hr0, s_min1, s_min0, t_hr1, t_hr0, t_min1, t_min0;
  logic load12, load24, setting12, setting24;
  logic [3:0] blink12, blink24;
  logic [15:0] set12, set24;

  assign set12 = {s_hr1, s_hr0, s_min1, s_min0};
  assign set24 = {t_hr1, t_hr0, t_min1, t_min0};

  clock_time_set #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .HOUR_MODE(12)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .cur_min0(cur[3:0]), .cur_min1(cur[7:4]), .cur_hr0(cur[11:8]), .cur_hr1(cur[15:12]),
    .set_min0(s_min0), .set_min1(s_min1), .set_hr0(s_hr0), .set_hr1(s_hr1),
    .load(load12), .setting(setting12), .blink_mask(blink12));

  clock_time_set #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .HOUR_MODE(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode24), .btn_up(btn_up24),
    .cur_min0(cur24[3:0]), .cur_min1(cur24[7:4]), .cur_hr0(cur24[11:8]), .cur_hr1(cur24[15:12]),
    .set_min0(t_min0), .set_min1(t_min1), .set_hr0(t_hr0), .set_hr1(t_hr1),
    .load(load24), .setting(setting24), .blink_mask(blink24));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int loads12  = 0;
  int loads24  = 0;
  logic [15:0] lv12 = '0;
  logic [15:0] lv24 = '0;

  always @(negedge clk) begin
    if (load12) begin loads12++; lv12 = set12; end
    if (load24) begin loads24++; lv24 = set24; end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit m, input bit u, input bit d24);
    if (d24) begin btn_mode24 = m; btn_up24 = u; end
    else begin btn_mode = m; btn_up = u; end
    repeat (DEB + 6) tick();
    btn_mode = 1'b0; btn_up = 1'b0; btn_mode24 = 1'b0; btn_up24 = 1'b0;
    repeat (DEB + 6) tick();
  endtask

  function automatic logic [15:0] bcd(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  // reference capture: plain arithmetic range checks on the live time
  task automatic model_capture(input logic [15:0] c, input bit is24, output int h, output int m);
    int hh, mmv;
    hh  = int'(c[15:12]) * 10 + int'(c[11:8]);
    mmv = int'(c[7:4]) * 10 + int'(c[3:0]);
    if (c[15:12] <= 9 && c[11:8] <= 9 && (is24 ? (hh <= 23) : (hh >= 1 && hh <= 12))) h = hh;
    else h = is24 ? 0 : 12;
    if (c[7:4] <= 9 && c[3:0] <= 9 && mmv <= 59) m = mmv;
    else m = 0;
  endtask

  typedef struct {
    bit          d24;
    bit          m;
    bit          u;
    logic [15:0] exp_set;
    logic [3:0]  exp_blink;
    int          exp_loads;
  } vec_t;

  vec_t vecs [11];

  int mh, mm, mst, mloads, exp_min, a, pulses, pulse_at;
  bit am, au;
  logic [3:0] d1, d0, e1, e0;

  initial begin
    vecs[0]  = '{0, 1, 0, 16'h1158, 4'b1100, 0};
    vecs[1]  = '{0, 0, 1, 16'h1258, 4'b1100, 0};
    vecs[2]  = '{0, 0, 1, 16'h0158, 4'b1100, 0};
    vecs[3]  = '{0, 1, 0, 16'h0158, 4'b0011, 0};
    vecs[4]  = '{0, 0, 1, 16'h0159, 4'b0011, 0};
    vecs[5]  = '{0, 1, 0, 16'h0159, 4'b0000, 1};
    vecs[6]  = '{1, 1, 0, 16'h2359, 4'b1100, 0};
    vecs[7]  = '{1, 0, 1, 16'h0059, 4'b1100, 0};
    vecs[8]  = '{1, 1, 0, 16'h0059, 4'b0011, 0};
    vecs[9]  = '{1, 0, 1, 16'h0000, 4'b0011, 0};
    vecs[10] = '{1, 1, 0, 16'h0000, 4'b0000, 1};

    rst_n = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_mode24 = 1'b0; btn_up24 = 1'b0;
    cur = 16'h1158; cur24 = 16'h2359;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    chk("rst_set12", set12, 16'h1200);
    chk("rst_set24", set24, 16'h0000);
    chk("rst_load", load12, 0);
    chk("rst_blink", blink12, 4'b0000);
    chk("rst_setting", setting12, 0);

    for (int i = 0; i < 11; i++) begin
      press(vecs[i].m, vecs[i].u, vecs[i].d24);
      if (vecs[i].d24) begin
        chk($sformatf("vec%0d_set", i), set24, vecs[i].exp_set);
        chk($sformatf("vec%0d_blink", i), blink24, vecs[i].exp_blink);
        chk($sformatf("vec%0d_setting", i), setting24, vecs[i].exp_blink != 4'b0000);
        chk($sformatf("vec%0d_loads", i), loads24, vecs[i].exp_loads);
      end else begin
        chk($sformatf("vec%0d_set", i), set12, vecs[i].exp_set);
        chk($sformatf("vec%0d_blink", i), blink12, vecs[i].exp_blink);
        chk($sformatf("vec%0d_setting", i), setting12, vecs[i].exp_blink != 4'b0000);
        chk($sformatf("vec%0d_loads", i), loads12, vecs[i].exp_loads);
      end
    end
    chk("load_val12", lv12, 16'h0159);
    chk("load_val24", lv24, 16'h0000);
    mh = 1; mm = 59; mst = 0; mloads = 1;

    // bouncing up button in RUN: a single debounced press, 7 cycles after the last rising edge
    btn_up = 1'b1; repeat (2) tick();
    btn_up = 1'b0; repeat (2) tick();
    btn_up = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (dut.up_p) begin pulses++; pulse_at = i; end
    end
    btn_up = 1'b0;
    repeat (DEB + 6) tick();
    chk("bounce_pulses", pulses, 1);
    chk("bounce_latency", pulse_at, DEB + 3);
    chk("bounce_run_hold", set12, bcd(mh, mm));

    // simultaneous mode+up in SET_HR, then reset mid-edit
    cur = 16'h0730;
    press(1, 0, 0);
    press(1, 1, 0);
    chk("both_set", set12, 16'h0730);
    chk("both_blink", blink12, 4'b0011);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_set", set12, 16'h1200);
    chk("abort_blink", blink12, 4'b0000);
    chk("abort_setting", setting12, 0);
    chk("abort_loads", loads12, mloads);
    chk("abort_set24", set24, 16'h0000);

    // held up in SET_MIN from 00
    cur = 16'h1000;
    press(1, 0, 0);
    press(1, 0, 0);
    btn_up = 1'b1;
    repeat (DEB + 3 + 50) tick();
    btn_up = 1'b0;
    repeat (DEB + 8) tick();
`ifdef CLOCK_TIME_SET_AUTOREPEAT_EN
    exp_min = 4;
`else
    exp_min = 1;
`endif
    chk("hold_min", set12, bcd(10, exp_min));
    press(1, 0, 0);
    mloads++;
    chk("hold_loads", loads12, mloads);
    chk("hold_load_val", lv12, bcd(10, exp_min));
    mh = 10; mm = exp_min; mst = 0;

    // random press sequence against the time model
    for (int k = 0; k < 40; k++) begin
      a  = $urandom_range(0, 2);
      am = (a != 1);
      au = (a != 0);
      if (am) begin
        if (mst == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            a  = $urandom_range(1, 12);
            d1 = 4'(a / 10); d0 = 4'(a % 10);
          end else begin
            d1 = 4'($urandom_range(0, 15)); d0 = 4'($urandom_range(0, 15));
          end
          e1 = 4'($urandom_range(0, 7)); e0 = 4'($urandom_range(0, 9));
          cur = {d1, d0, e1, e0};
          model_capture(cur, 1'b0, mh, mm);
          mst = 1;
        end else if (mst == 1) begin
          mst = 2;
        end else begin
          mst = 0;
          mloads++;
        end
      end else if (mst == 1) begin
        mh = mh % 12 + 1;
      end else if (mst == 2) begin
        mm = (mm + 1) % 60;
      end
      press(am, au, 0);
      chk($sformatf("rnd%0d_set", k), set12, bcd(mh, mm));
      chk($sformatf("rnd%0d_blink", k), blink12, (mst == 1) ? 4'b1100 : (mst == 2) ? 4'b0011 : 4'b0000);
      chk($sformatf("rnd%0d_setting", k), setting12, mst != 0);
      chk($sformatf("rnd%0d_loads", k), loads12, mloads);
      if (am && mst == 0) chk($sformatf("rnd%0d_load_val", k), lv12, bcd(mh, mm));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
